// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencing controller.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FINISH
  } mac_state_e;

  localparam int MODE_MUL = 0;
  localparam int MODE_ACC = 1;

endpackage

// File: rtl/mac_valid_pipe.sv
// Fixed-depth valid delay line tracking samples in flight through the datapath.
module mac_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_valid,
  output logic o_valid
);

  logic [DEPTH-1:0] r_pipe;

  // Shift form keeps DEPTH=1 legal without a separate generate branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
    end else if (i_clear) begin
      r_pipe <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | DEPTH'(i_valid);
    end
  end

  assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Run sequencer for a MAC datapath: mode latch, accumulator clear, valid tracking, end-of-run.
// Optional sample counter is built when MAC_SEQ_CNT_EN is defined.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int                   NUM_MODES     = 4,
  parameter int                   MODE_W        = 2,
  parameter int                   PIPE_LAT      = 3,
  parameter logic [NUM_MODES-1:0] ACC_MODE_MASK = 4'b1010,
  parameter int                   CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MODE_W-1:0]    mode,
  input  logic                 valid_in,
  input  logic                 last_in,
  output logic                 in_ready,
  output logic [NUM_MODES-1:0] enable,
  output logic                 acc_clear,
  output logic                 valid_out,
  output logic                 result_acc,
  output logic                 done,
  output logic                 mode_err
`ifdef MAC_SEQ_CNT_EN
  ,
  output logic [CNT_W-1:0]     sample_cnt
`endif
);

  localparam int                MASK_W       = 2 ** MODE_W;
  localparam logic [MODE_W:0]   NUM_MODES_C  = (MODE_W + 1)'(NUM_MODES);
  localparam logic [MASK_W-1:0] ACC_MASK_EXT = MASK_W'(ACC_MODE_MASK);
  localparam logic [3:0]        DRAIN_LOAD   = 4'(PIPE_LAT - 1);

  mac_state_e        r_state;
  logic [MODE_W-1:0] r_mode;
  logic [3:0]        r_drain_cnt;

  logic w_accept;
  logic w_legal;
  logic w_first;
  logic w_run_accept;
  logic w_mode_acc;
  logic w_push;
  logic w_pipe_clear;

  assign w_accept     = valid_in & in_ready;
  assign w_legal      = ({1'b0, mode} < NUM_MODES_C);
  assign w_first      = w_accept & (r_state == ST_IDLE) & w_legal;
  assign w_run_accept = w_accept & (r_state == ST_RUN);

  // In IDLE the mode is not latched yet, so the live input decides the kind of run.
  assign w_mode_acc   = (r_state == ST_IDLE) ? ACC_MASK_EXT[mode] : ACC_MASK_EXT[r_mode];
  assign w_push       = (w_first | w_run_accept) & (~w_mode_acc | last_in);
  assign w_pipe_clear = (r_state == ST_FINISH);

  mac_valid_pipe #(
    .DEPTH (PIPE_LAT)
  ) u_valid_pipe (
    .clk     (clk),
    .rst     (reset),
    .i_clear (w_pipe_clear),
    .i_valid (w_push),
    .o_valid (valid_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= '0;
      r_drain_cnt <= '0;
      in_ready    <= 1'b1;
      enable      <= '0;
      acc_clear   <= 1'b0;
      result_acc  <= 1'b0;
      done        <= 1'b0;
      mode_err    <= 1'b0;
    end else begin
      acc_clear <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_mode     <= mode;
              enable     <= NUM_MODES'(1) << mode;
              result_acc <= ACC_MASK_EXT[mode];
              acc_clear  <= ACC_MASK_EXT[mode];
              if (last_in) begin
                r_state     <= ST_DRAIN;
                in_ready    <= 1'b0;
                r_drain_cnt <= DRAIN_LOAD;
                done        <= (DRAIN_LOAD == 4'd0);
              end else begin
                r_state <= ST_RUN;
              end
            end else begin
              mode_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_accept && last_in) begin
            r_state     <= ST_DRAIN;
            in_ready    <= 1'b0;
            r_drain_cnt <= DRAIN_LOAD;
            done        <= (DRAIN_LOAD == 4'd0);
          end
        end
        // Counter hits zero in the cycle the last sample's result leaves the pipe.
        ST_DRAIN: begin
          if (r_drain_cnt == 4'd0) begin
            r_state <= ST_FINISH;
          end else begin
            r_drain_cnt <= r_drain_cnt - 4'd1;
            done        <= (r_drain_cnt == 4'd1);
          end
        end
        ST_FINISH: begin
          r_state    <= ST_IDLE;
          in_ready   <= 1'b1;
          enable     <= '0;
          result_acc <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MAC_SEQ_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt <= '0;
    end else if (w_first) begin
      sample_cnt <= CNT_W'(1);
    end else if (w_run_accept && (sample_cnt != '1)) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: vector table, directed corner sequences, random runs.
module tb_mac_seq_ctrl;
  import mac_pkg::*;

  localparam int         PL       = 3;
  localparam int         CNT_MAX  = 3;
  localparam logic [3:0] ACC_MASK = 4'b1010;

  logic       clk;
  logic       reset;
  logic [2:0] mode;
  logic       valid_in;
  logic       last_in;
  logic       in_ready;
  logic [3:0] enable;
  logic       acc_clear;
  logic       valid_out;
  logic       result_acc;
  logic       done;
  logic       mode_err;
`ifdef MAC_SEQ_CNT_EN
  logic [1:0] sample_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit exp_err = 0;

  mac_seq_ctrl #(
    .NUM_MODES     (4),
    .MODE_W        (3),
    .PIPE_LAT      (PL),
    .ACC_MODE_MASK (ACC_MASK),
    .CNT_W         (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .valid_in   (valid_in),
    .last_in    (last_in),
    .in_ready   (in_ready),
    .enable     (enable),
    .acc_clear  (acc_clear),
    .valid_out  (valid_out),
    .result_acc (result_acc),
    .done       (done),
    .mode_err   (mode_err)
`ifdef MAC_SEQ_CNT_EN
    ,
    .sample_cnt (sample_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       v;
    logic       l;
    logic [2:0] m;
    logic       rdy;
    logic [3:0] en;
    logic       clr;
    logic       vo;
    logic       ra;
    logic       dn;
    logic       err;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic v, logic l, logic [2:0] m, logic rdy, logic [3:0] en,
                              logic clr, logic vo, logic ra, logic dn, logic err);
    vec_t x;
    x.v = v; x.l = l; x.m = m; x.rdy = rdy; x.en = en;
    x.clr = clr; x.vo = vo; x.ra = ra; x.dn = dn; x.err = err;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One complete run planned up front: accept cycles are known, so every
  // expected output follows from arithmetic on those cycle numbers.
  task automatic do_run(input int md, input int n, input int gmin, input int gmax, input bit inject);
    int   a[$];
    int   t;
    int   last;
    int   fin;
    int   nacc;
    bit   acc;
    logic [3:0] oh;
    acc  = ACC_MASK[md];
    oh   = 4'b0001 << md;
    t    = int'($urandom_range(gmax, gmin));
    for (int i = 0; i < n; i++) begin
      if (i > 0) t += 1 + int'($urandom_range(gmax, gmin));
      a.push_back(t);
    end
    last = a[n-1];
    fin  = last + PL + 2;
    nacc = 0;
    for (int r = 0; r <= fin; r++) begin
      bit is_acc;
      bit inj;
      bit exp_vo;
      bit in_win;
      inj    = 1'b0;
      is_acc = (nacc < n) && (a[nacc] == r);
      if (is_acc) begin
        valid_in = 1'b1;
        last_in  = (nacc == n - 1);
        mode     = (nacc == 0) ? 3'(md) : 3'($urandom_range(7, 0));
      end else if (r < a[0]) begin
        inj      = inject && ($urandom_range(3, 0) == 0);
        valid_in = inj;
        last_in  = 1'($urandom_range(1, 0));
        mode     = inj ? 3'(4 + $urandom_range(3, 0)) : 3'($urandom_range(3, 0));
      end else if (r <= last) begin
        valid_in = 1'b0;
        last_in  = 1'($urandom_range(1, 0));
        mode     = 3'($urandom_range(7, 0));
      end else if (r < fin) begin
        valid_in = 1'($urandom_range(1, 0));
        last_in  = 1'($urandom_range(1, 0));
        mode     = 3'($urandom_range(7, 0));
      end else begin
        valid_in = 1'b0;
        last_in  = 1'b0;
        mode     = 3'd0;
      end
      exp_vo = 1'b0;
      if (acc) exp_vo = (r == last + PL);
      else foreach (a[i]) if (a[i] + PL == r) exp_vo = 1'b1;
      in_win = (r > a[0]) && (r <= last + PL + 1);
      @(negedge clk);
      chk("valid_out",  valid_out,  exp_vo);
      chk("done",       done,       r == last + PL);
      chk("in_ready",   in_ready,   !(r > last && r <= last + PL + 1));
      chk("acc_clear",  acc_clear,  acc && (r == a[0] + 1));
      chk("enable",     enable,     in_win ? oh : 4'b0000);
      chk("result_acc", result_acc, in_win && acc);
      chk("mode_err",   mode_err,   exp_err);
`ifdef MAC_SEQ_CNT_EN
      if (r > a[0]) chk("sample_cnt", sample_cnt, (nacc > CNT_MAX) ? CNT_MAX : nacc);
`endif
      tick();
      if (is_acc) nacc++;
      if (inj) exp_err = 1'b1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},   in_ready,   1);
    chk({tag, "_enable"},     enable,     0);
    chk({tag, "_acc_clear"},  acc_clear,  0);
    chk({tag, "_valid_out"},  valid_out,  0);
    chk({tag, "_result_acc"}, result_acc, 0);
    chk({tag, "_done"},       done,       0);
    chk({tag, "_mode_err"},   mode_err,   0);
`ifdef MAC_SEQ_CNT_EN
    chk({tag, "_sample_cnt"}, sample_cnt, 0);
`endif
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    mode     = 3'd0;

    // streaming mode 0: 4 back-to-back samples, mode wiggles and DRAIN traffic ignored
    tbl[0]  = mk(1, 0, 3'(MODE_MUL), 1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 3'd2,         1, 4'b0001, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 3'd1,         1, 4'b0001, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 3'd0,         1, 4'b0001, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 0, 3'd3,         0, 4'b0001, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 3'd0,         0, 4'b0001, 0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 1, 3'd1,         0, 4'b0001, 0, 1, 0, 1, 0);
    tbl[7]  = mk(0, 0, 3'd0,         0, 4'b0001, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 3'd0,         1, 4'b0000, 0, 0, 0, 0, 0);
    // one-sample accumulating run in mode 3
    tbl[9]  = mk(1, 1, 3'd3,         1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 3'd0,         0, 4'b1000, 1, 0, 1, 0, 0);
    tbl[11] = mk(0, 0, 3'd0,         0, 4'b1000, 0, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 3'd0,         0, 4'b1000, 0, 1, 1, 1, 0);
    tbl[13] = mk(0, 0, 3'd0,         0, 4'b1000, 0, 0, 1, 0, 0);
    tbl[14] = mk(0, 0, 3'd0,         1, 4'b0000, 0, 0, 0, 0, 0);
    // illegal mode 5 in IDLE: sticky error, sample dropped
    tbl[15] = mk(1, 1, 3'd5,         1, 4'b0000, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 3'd0,         1, 4'b0000, 0, 0, 0, 0, 1);
    tbl[17] = mk(0, 0, 3'd0,         1, 4'b0000, 0, 0, 0, 0, 1);
    tbl[18] = mk(0, 0, 3'd0,         1, 4'b0000, 0, 0, 0, 0, 1);
    tbl[19] = mk(0, 0, 3'd0,         1, 4'b0000, 0, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      valid_in = tbl[i].v;
      last_in  = tbl[i].l;
      mode     = tbl[i].m;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i),   in_ready,   tbl[i].rdy);
      chk($sformatf("tbl%0d_enable", i),     enable,     tbl[i].en);
      chk($sformatf("tbl%0d_acc_clear", i),  acc_clear,  tbl[i].clr);
      chk($sformatf("tbl%0d_valid_out", i),  valid_out,  tbl[i].vo);
      chk($sformatf("tbl%0d_result_acc", i), result_acc, tbl[i].ra);
      chk($sformatf("tbl%0d_done", i),       done,       tbl[i].dn);
      chk($sformatf("tbl%0d_mode_err", i),   mode_err,   tbl[i].err);
      tick();
    end

    // reset two cycles after a mode-0 sample kills its pending result
    valid_in = 1'b1;
    last_in  = 1'b0;
    mode     = 3'(MODE_MUL);
    tick();
    valid_in = 1'b0;
    @(negedge clk);
    chk("rst_pre_enable", enable, 4'b0001);
    tick();
    reset = 1'b1;
    #1;
    chk_reset_vals("midrun");
    tick();
    tick();
    reset   = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_valid_out", valid_out, 0);
      chk("post_rst_done",      done,      0);
      chk("post_rst_in_ready",  in_ready,  1);
      chk("post_rst_enable",    enable,    0);
      tick();
    end

    do_run(MODE_ACC, 5, 1, 3, 1'b0);
    do_run(MODE_MUL, 6, 0, 0, 1'b0);
    do_run(3, 1, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      do_run(int'($urandom_range(3, 0)), int'($urandom_range(6, 1)), 0, 2, 1'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
